cdec8_ctrl: RTL and testbench
=============================

# cdec8_ctrl

Control sequencer for the CDEC8 processor. Sits directly upstream of the CDEC8 datapath: consumes the datapath's instruction register `I` and flags `SZCy`, and drives the 15-bit `ctrl` word that selects XBUS source/destination, ALU operation, R/FLG write enables and memory read/write each cycle. Also exports its state code for the PC debug monitor at resource address 0x0B.

## Interface
Parameters: none.

- `clock`    in   1   system clock; all state changes on its rising edge.
- `reset_N`  in   1   synchronous, active-low reset.
- `I`        in   8   instruction register from the datapath.
- `SZCy`     in   3   flags from the datapath: [2]=S, [1]=Z, [0]=Cy.
- `run`      in   1   run enable; sampled only in state F0.
- `ctrl`     out  15  {mmrw[14:13], fwr[12], rwr[11], xdst[10:8], aluop[7:3], xsrc[2:0]}.
- `state`    out  8   current state code (debug monitor).
- `halt`     out  1   1 while in HALT.

## Operation
- Encodings: xsrc 000 PC, 001 A, 010 B, 011 C, 100 R, 101 RDR, 110 FLG, 111 0xFF. xdst 000 PC, 001 A, 010 B, 011 C, 100 MAR, 101 WDR, 110 T, 111 I. mmrw 10 = memory read into RDR, 01 = memory write of WDR at MAR, 00 = none. aluop 5'h10 = X+1.
- Idle word 15'h0000 = PC←PC, no memory, no R/FLG write. Every state not listed below drives the idle word.
- Register field r=I[1:0]: 01 A, 10 B, 11 C; used as xsrc={0,r} / xdst={0,r}. r=00 on LDI/LD/ST/ALU → treated as NOP.
- Instruction groups (decoded in DC from I):
  - 0x0F HLT → HALT. All other 0x0x, and all of 0x9x–0xFx except JMP codes, → NOP.
  - 0x1r LDI r,imm; 0x2r LD r,[a]; 0x3r ST r,[a]; 0x80–0x87 JMP/Jcc a. Each fetches a second byte.
  - 01ffffrr ALU: r ← f(X=r, T=A) written to A; aluop={1'b0, I[5:2]}.
- Jcc: I[1:0] 00 always, 01 Z, 10 Cy, 11 S; I[2]=1 inverts. SZCy sampled in O2.
- States (code: ctrl):
  - F0 0x00: MAR←PC. If run=0 stay in F0, else F1.
  - F1 0x01: mmrw=10; R←PC+1, with xsrc/xdst PC.
  - F2 0x02: PC←R.
  - F3 0x03: I←RDR.
  - DC 0x04: idle. NOP → F0; HLT → HALT; ALU → A0; others → O0.
  - O0 0x10 / O1 0x11 / O2 0x12: same as F0/F1/F2, with no run check.
    - After O2: LDI, LD, ST and taken jump → X0; untaken jump → F0.
  - X0 0x20:
    - LDI: r←RDR → F0.
    - LD/ST: MAR←RDR → X1.
    - Jump: PC←RDR → F0.
  - X1 0x21:
    - LD: mmrw=10 → X2.
    - ST: WDR←r → X2.
  - X2 0x22:
    - LD: r←RDR → F0.
    - ST: mmrw=01 → F0.
  - A0 0x30: T←A.
  - A1 0x31: xsrc=r, xdst=r, aluop, rwr=1, fwr=1.
  - A2 0x32: A←R → F0.
  - HALT 0xFF: idle word; halt=1. Left only by reset.

## Timing
- Moore outputs: ctrl, state and halt are combinational from the state register, plus registered I for field selects.
- Reset:
  - While reset_N=0: ctrl=15'h0000 and halt=0.
  - At the edge with reset_N=0: state←F0. This applies from any state, mid-instruction and HALT included.
- Cycles per instruction: NOP 5, ALU 8, untaken jump 8, LDI 9, taken jump 9, LD 11, ST 11. HLT reaches HALT after 5 cycles.
- I is valid from DC onward, since it is loaded at the end of F3.
- Memory is combinational read: RDR captures data_in at the end of a mmrw=10 cycle. A write commits at the end of the mmrw=01 cycle.
- run=0 in F0 holds F0 and repeats MAR←PC. run is ignored in every other state.
- Values outside the decoded groups never produce mmrw=11.

## Test plan
- Reset: reset_N=0 for 2 cycles from an arbitrary state (incl. HALT) → ctrl=0x0000, halt=0; after release with run=1, state 0x00 and ctrl=0x0400.
- NOP fetch, I=0x00 → states 00,01,02,03,04,00 with ctrl 0x0400, 0x4880, 0x0004, 0x0705, 0x0000. With run=0 in F0 → state stays 0x00.
- ALU, I=0x42 → after DC, A0 ctrl=0x0601, A1 ctrl=0x1A02, A2 ctrl=0x0104, then F0.
- Jump, I=0x81:
  - SZCy=3'b010 → O0–O2, then X0 ctrl=0x0005, then F0.
  - SZCy=3'b000 → F0 directly after O2.
  - I=0x85 with SZCy=3'b010 → not taken.
- ST, I=0x33 → X0 0x0405, X1 0x0503, X2 0x2000.
- LD, I=0x21 → X0 0x0405, X1 0x4000, X2 0x0105.
- HLT, I=0x0F → state 0xFF, halt=1, ctrl=0x0000 for 20 cycles regardless of run and SZCy. Then reset_N=0 for 1 cycle → state 0x00.

Source files
------------

// File: rtl/cdec8_ctrl.sv
// CDEC8 control sequencer: Moore FSM that turns the instruction register
// and datapath flags into the 15-bit per-cycle control word.
//
// Ports:
//   clock    rising-edge clock
//   reset_N  synchronous active-low reset (returns to F0 from any state)
//   I        instruction register from the datapath
//   SZCy     flags {S, Z, Cy}
//   run      run enable, sampled only in F0
//   ctrl     {mmrw[1:0], fwr, rwr, xdst[2:0], aluop[4:0], xsrc[2:0]}
//   state    current state code for the debug monitor
//   halt     high while in HALT
module cdec8_ctrl (
  input  logic        clock,
  input  logic        reset_N,
  input  logic [7:0]  I,
  input  logic [2:0]  SZCy,
  input  logic        run,
  output logic [14:0] ctrl,
  output logic [7:0]  state,
  output logic        halt
);

  typedef enum logic [7:0] {
    F0   = 8'h00,
    F1   = 8'h01,
    F2   = 8'h02,
    F3   = 8'h03,
    DC   = 8'h04,
    O0   = 8'h10,
    O1   = 8'h11,
    O2   = 8'h12,
    X0   = 8'h20,
    X1   = 8'h21,
    X2   = 8'h22,
    A0   = 8'h30,
    A1   = 8'h31,
    A2   = 8'h32,
    HALT = 8'hFF
  } state_t;

  typedef enum logic [2:0] {
    C_NOP,
    C_HLT,
    C_LDI,
    C_LD,
    C_ST,
    C_JMP,
    C_ALU
  } cls_t;

  localparam logic [2:0] S_PC  = 3'b000;
  localparam logic [2:0] S_A   = 3'b001;
  localparam logic [2:0] S_R   = 3'b100;
  localparam logic [2:0] S_RDR = 3'b101;

  localparam logic [2:0] D_PC  = 3'b000;
  localparam logic [2:0] D_A   = 3'b001;
  localparam logic [2:0] D_MAR = 3'b100;
  localparam logic [2:0] D_WDR = 3'b101;
  localparam logic [2:0] D_T   = 3'b110;
  localparam logic [2:0] D_I   = 3'b111;

  localparam logic [1:0] M_RD  = 2'b10;
  localparam logic [1:0] M_WR  = 2'b01;
  localparam logic [4:0] OP_INC = 5'h10;

  state_t     state_q;
  state_t     nxt;
  cls_t       cls;
  logic [1:0] r;
  logic       cond;
  logic       taken;

  logic [1:0] mmrw;
  logic       fwr;
  logic       rwr;
  logic [2:0] xdst;
  logic [4:0] aluop;
  logic [2:0] xsrc;

  assign r = I[1:0];

  // r=00 on a register-using group degrades to NOP.
  always_comb begin
    cls = C_NOP;
    unique case (1'b1)
      (I == 8'h0F):       cls = C_HLT;
      (I[7:6] == 2'b01):  cls = (r != 2'b00) ? C_ALU : C_NOP;
      (I[7:4] == 4'h1):   cls = (r != 2'b00) ? C_LDI : C_NOP;
      (I[7:4] == 4'h2):   cls = (r != 2'b00) ? C_LD  : C_NOP;
      (I[7:4] == 4'h3):   cls = (r != 2'b00) ? C_ST  : C_NOP;
      (I[7:3] == 5'h10):  cls = C_JMP;
      default:            cls = C_NOP;
    endcase
  end

  // Condition select: 00 always, 01 Z, 10 Cy, 11 S; I[2] inverts.
  always_comb begin
    cond = 1'b1;
    unique case (r)
      2'b00: cond = 1'b1;
      2'b01: cond = SZCy[1];
      2'b10: cond = SZCy[0];
      2'b11: cond = SZCy[2];
      default: cond = 1'b1;
    endcase
  end

  assign taken = cond ^ I[2];

  always_ff @(posedge clock) begin
    if (!reset_N) state_q <= F0;
    else          state_q <= nxt;
  end

  always_comb begin
    nxt   = state_q;
    mmrw  = 2'b00;
    fwr   = 1'b0;
    rwr   = 1'b0;
    xdst  = D_PC;
    aluop = 5'h00;
    xsrc  = S_PC;
    unique case (state_q)
      F0: begin
        xsrc = S_PC;
        xdst = D_MAR;
        nxt  = run ? F1 : F0;
      end
      F1: begin
        mmrw  = M_RD;
        rwr   = 1'b1;
        aluop = OP_INC;
        nxt   = F2;
      end
      F2: begin
        xsrc = S_R;
        nxt  = F3;
      end
      F3: begin
        xsrc = S_RDR;
        xdst = D_I;
        nxt  = DC;
      end
      DC: begin
        unique case (cls)
          C_NOP:   nxt = F0;
          C_HLT:   nxt = HALT;
          C_ALU:   nxt = A0;
          default: nxt = O0;
        endcase
      end
      O0: begin
        xdst = D_MAR;
        nxt  = O1;
      end
      O1: begin
        mmrw  = M_RD;
        rwr   = 1'b1;
        aluop = OP_INC;
        nxt   = O2;
      end
      O2: begin
        xsrc = S_R;
        if (cls == C_JMP && !taken) nxt = F0;
        else                        nxt = X0;
      end
      X0: begin
        xsrc = S_RDR;
        unique case (cls)
          C_LDI: begin
            xdst = {1'b0, r};
            nxt  = F0;
          end
          C_LD, C_ST: begin
            xdst = D_MAR;
            nxt  = X1;
          end
          C_JMP: begin
            xdst = D_PC;
            nxt  = F0;
          end
          default: begin
            xsrc = S_PC;
            nxt  = F0;
          end
        endcase
      end
      X1: begin
        unique case (cls)
          C_LD: begin
            mmrw = M_RD;
            nxt  = X2;
          end
          C_ST: begin
            xsrc = {1'b0, r};
            xdst = D_WDR;
            nxt  = X2;
          end
          default: nxt = F0;
        endcase
      end
      X2: begin
        unique case (cls)
          C_LD: begin
            xsrc = S_RDR;
            xdst = {1'b0, r};
          end
          C_ST:    mmrw = M_WR;
          default: mmrw = 2'b00;
        endcase
        nxt = F0;
      end
      A0: begin
        xsrc = S_A;
        xdst = D_T;
        nxt  = A1;
      end
      A1: begin
        xsrc  = {1'b0, r};
        xdst  = {1'b0, r};
        aluop = {1'b0, I[5:2]};
        rwr   = 1'b1;
        fwr   = 1'b1;
        nxt   = A2;
      end
      A2: begin
        xsrc = S_R;
        xdst = D_A;
        nxt  = F0;
      end
      HALT:    nxt = HALT;
      default: nxt = F0;
    endcase
  end

  // Reset forces the idle word immediately, not just after the edge.
  assign ctrl  = reset_N ? {mmrw, fwr, rwr, xdst, aluop, xsrc} : 15'h0000;
  assign state = state_q;
  assign halt  = reset_N && (state_q == HALT);

endmodule

// File: tb/tb_cdec8_ctrl.sv
// Directed bench for cdec8_ctrl: walks each instruction group through
// its state sequence and checks state/ctrl/halt against hand values.
module tb_cdec8_ctrl;

  logic        clock;
  logic        reset_N;
  logic [7:0]  I;
  logic [2:0]  SZCy;
  logic        run;
  logic [14:0] ctrl;
  logic [7:0]  state;
  logic        halt;

  int checks;
  int errors;

  cdec8_ctrl dut (
    .clock   (clock),
    .reset_N (reset_N),
    .I       (I),
    .SZCy    (SZCy),
    .run     (run),
    .ctrl    (ctrl),
    .state   (state),
    .halt    (halt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [7:0] st,
                     input logic [14:0] cw);
    chk({tag, ".state"}, {8'h00, state}, {8'h00, st});
    chk({tag, ".ctrl"}, {1'b0, ctrl}, {1'b0, cw});
    chk({tag, ".halt"}, {15'h0, halt}, 16'h0);
    tick();
  endtask

  task automatic fetch(input string tag);
    cyc({tag, ".F0"}, 8'h00, 15'h0400);
    cyc({tag, ".F1"}, 8'h01, 15'h4880);
    cyc({tag, ".F2"}, 8'h02, 15'h0004);
    cyc({tag, ".F3"}, 8'h03, 15'h0705);
    cyc({tag, ".DC"}, 8'h04, 15'h0000);
  endtask

  task automatic operand(input string tag);
    cyc({tag, ".O0"}, 8'h10, 15'h0400);
    cyc({tag, ".O1"}, 8'h11, 15'h4880);
    cyc({tag, ".O2"}, 8'h12, 15'h0004);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_N = 1'b0;
    run     = 1'b1;
    I       = 8'h00;
    SZCy    = 3'b000;
    #1;
    chk("rst.ctrl", {1'b0, ctrl}, 16'h0000);
    chk("rst.halt", {15'h0, halt}, 16'h0);
    tick();
    tick();
    chk("rst.state", {8'h00, state}, 16'h0000);
    reset_N = 1'b1;
    #1;
    chk("rst.rel_ctrl", {1'b0, ctrl}, 16'h0400);

    // NOP
    I = 8'h00;
    fetch("nop");
    chk("nop.end", {8'h00, state}, 16'h0000);

    // run=0 holds F0
    run = 1'b0;
    cyc("hold0", 8'h00, 15'h0400);
    cyc("hold1", 8'h00, 15'h0400);
    cyc("hold2", 8'h00, 15'h0400);
    run = 1'b1;

    // ALU I=0x42
    I = 8'h42;
    fetch("alu");
    cyc("alu.A0", 8'h30, 15'h0601);
    cyc("alu.A1", 8'h31, 15'h1A02);
    cyc("alu.A2", 8'h32, 15'h0104);
    chk("alu.end", {8'h00, state}, 16'h0000);

    // JZ taken
    I = 8'h81;
    SZCy = 3'b010;
    fetch("jz_t");
    operand("jz_t");
    cyc("jz_t.X0", 8'h20, 15'h0005);
    chk("jz_t.end", {8'h00, state}, 16'h0000);

    // JZ not taken
    SZCy = 3'b000;
    fetch("jz_n");
    operand("jz_n");
    chk("jz_n.end", {8'h00, state}, 16'h0000);

    // JNZ with Z=1 not taken
    I = 8'h85;
    SZCy = 3'b010;
    fetch("jnz");
    operand("jnz");
    chk("jnz.end", {8'h00, state}, 16'h0000);

    // ST C
    I = 8'h33;
    SZCy = 3'b000;
    fetch("st");
    operand("st");
    cyc("st.X0", 8'h20, 15'h0405);
    cyc("st.X1", 8'h21, 15'h0503);
    cyc("st.X2", 8'h22, 15'h2000);
    chk("st.end", {8'h00, state}, 16'h0000);

    // LD A
    I = 8'h21;
    fetch("ld");
    operand("ld");
    cyc("ld.X0", 8'h20, 15'h0405);
    cyc("ld.X1", 8'h21, 15'h4000);
    cyc("ld.X2", 8'h22, 15'h0105);
    chk("ld.end", {8'h00, state}, 16'h0000);

    // LDI B
    I = 8'h12;
    fetch("ldi");
    operand("ldi");
    cyc("ldi.X0", 8'h20, 15'h0205);
    chk("ldi.end", {8'h00, state}, 16'h0000);

    // LD with r=00 is a NOP
    I = 8'h20;
    fetch("ld0");
    chk("ld0.end", {8'h00, state}, 16'h0000);

    // Reset mid-instruction (ALU, in A1)
    I = 8'h43;
    fetch("mid");
    cyc("mid.A0", 8'h30, 15'h0601);
    reset_N = 1'b0;
    #1;
    chk("mid.rst_ctrl", {1'b0, ctrl}, 16'h0000);
    tick();
    reset_N = 1'b1;
    #1;
    chk("mid.state", {8'h00, state}, 16'h0000);

    // HLT
    I = 8'h0F;
    fetch("hlt");
    for (int k = 0; k < 20; k++) begin
      chk("hlt.state", {8'h00, state}, 16'h00FF);
      chk("hlt.halt", {15'h0, halt}, 16'h1);
      chk("hlt.ctrl", {1'b0, ctrl}, 16'h0000);
      run  = 1'($urandom_range(0, 1));
      SZCy = 3'($urandom_range(0, 7));
      tick();
    end
    reset_N = 1'b0;
    #1;
    chk("hlt.rst_halt", {15'h0, halt}, 16'h0);
    chk("hlt.rst_ctrl", {1'b0, ctrl}, 16'h0000);
    tick();
    reset_N = 1'b1;
    run = 1'b1;
    #1;
    chk("hlt.rel_state", {8'h00, state}, 16'h0000);
    chk("hlt.rel_ctrl", {1'b0, ctrl}, 16'h0400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
